hitframe_tx: RTL and testbench
==============================

# hitframe_tx

Frame transmitter that produces the byte-stream data channel consumed by the IPbus RAM dump logic. On a trigger it:
- pulses the dump request;
- reads 256 32-bit hit counters from the counter bank;
- serialises them MSB-first as 1024 write-enabled bytes;
- waits for the receiver's dump-done before accepting the next trigger.

It sits between the hit-counter bank and the RAM packing/handshake block.

## Interface
Parameters:
- `NWORDS`, 256: words per frame. Must be ≤ 256.
- `STROBE_GAP`, 0: idle cycles inserted between consecutive byte strobes (0–15).

Ports:
- `SYSCLK`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `trigger`  in  1  level; sampled only in IDLE; starts a frame.
- `cnt_addr`  out  8  counter-bank read address.
- `cnt_data`  in  32  counter-bank read data; valid the cycle after `cnt_addr`.
- `cnt_clr`  out  1  clear strobe for the word at `cnt_addr` (macro-dependent).
- `dumpMem`  out  1  one-cycle dump request to the receiver.
- `write_En_datachannel`  out  1  byte strobe.
- `data_datachannel`  out  8  byte payload; valid when the strobe is high.
- `dumpdone`  in  1  receiver frame-complete pulse.
- `busy`  out  1  high in every state except IDLE.
- `trig_dropped`  out  1  one-cycle pulse when `trigger` is high while busy.

## Operation
- **Reset values:** all outputs 0, state IDLE, byte counter 0, word counter 0, done flag 0.
- **States and transitions:**
  - IDLE → REQ when `trigger`=1.
  - REQ → FETCH after 1 cycle. In REQ: `dumpMem`=1 and `cnt_addr`=0.
  - FETCH → SEND after 1 cycle. FETCH waits out the counter-bank read latency.
  - SEND → GAP after each byte when `STROBE_GAP`>0.
  - GAP → SEND after `STROBE_GAP` cycles.
  - SEND → DRAIN after byte 1023.
  - DRAIN → IDLE when the done flag is set.
- **SEND behaviour:**
  - The word is loaded into a 32-bit shift register.
  - Bytes go out as [31:24], [23:16], [15:8], [7:0], one strobe each.
  - The next word's address is issued at byte index 2 of the current word, so words stream back-to-back without a bubble.
- **Counters:**
  - Word counter is 8 bits, 0..NWORDS−1. It has no wrap within a frame and is cleared on entry to IDLE.
  - Byte counter is 10 bits. The frame ends when it reaches 4·NWORDS−1.
- **Done flag:**
  - Set by `dumpdone` at any time from REQ onward; cleared in IDLE.
  - An early `dumpdone` (before the last byte) does not truncate the frame. All bytes are still sent, then the block exits DRAIN on the following cycle.
- **`trig_dropped`:** pulses on each busy cycle where `trigger`=1. Dropped triggers are not queued.
- **Reset mid-frame:** on the next edge the state goes to IDLE, the strobe and `dumpMem` go to 0, and no further bytes are emitted.
- **Simultaneous events:**
  - `trigger` and `reset` together: reset wins.
  - `dumpdone` in the same cycle as the last strobe: the flag is set, and the block exits DRAIN one cycle later.

## Timing
Cycle T is the IDLE cycle in which `trigger`=1.
- T+1: `dumpMem`=1, `cnt_addr`=0.
- T+2: `cnt_data` word 0 is valid and loaded.
- T+3: first strobe, byte = word0[31:24].
- With `STROBE_GAP`=0: one strobe per cycle, and the last strobe is at T+2+4·NWORDS (T+1026 at the default).
- General case: strobe n occurs at T+3+n·(1+`STROBE_GAP`).
- `busy` rises at T+1 and falls on the cycle after DRAIN exit.
- The minimum trigger-to-trigger period is the frame length plus 2 cycles.

## Configuration
Macro: `HITFRAME_TX_CLEAR_EN`.
- **Defined:** `cnt_clr` pulses for one cycle on the same cycle the word is loaded into the shift register, with `cnt_addr` still holding that word's address. Every counter is read-and-cleared once per frame.
- **Undefined:** `cnt_clr` is tied to 0 and counters accumulate across frames.

## Test plan
- **Single frame:** reset, then `trigger` at T with `cnt_data` = address·0x01010101 and `STROBE_GAP`=0.
  - `dumpMem` at T+1 only.
  - 1024 contiguous strobes from T+3.
  - Bytes 0..3 are 00 00 00 00; bytes 4..7 are 01 01 01 01.
  - Byte 1023 is 0xFF at T+1026.
- **Gap pacing:** `STROBE_GAP`=3.
  - Strobes exactly 4 cycles apart.
  - Last strobe at T+3+1023·4.
  - `busy` high throughout.
- **Early dumpdone:** pulse `dumpdone` at T+500.
  - All 1024 bytes are still emitted.
  - `busy` falls 2 cycles after the last strobe.
- **Late dumpdone:** `dumpdone` arrives 50 cycles after the last strobe.
  - The block holds DRAIN with no strobes.
  - It enters IDLE the cycle after `dumpdone`.
  - A `trigger` in DRAIN gives a `trig_dropped` pulse.
- **Reset mid-frame:** assert `reset` at strobe 300.
  - Strobe and `busy` are 0 next cycle.
  - A new `trigger` restarts at word 0, byte 0.
- **Clear feature:** with `HITFRAME_TX_CLEAR_EN` defined, exactly 256 `cnt_clr` pulses occur, addresses 0..255 ascending. With it undefined, `cnt_clr` stays 0.

Source files
------------

// File: rtl/hitframe_tx_if.sv
// Counter-bank read port plus byte data channel between hitframe_tx and the RAM dump side.
interface hitframe_tx_if;
    logic [7:0]  cnt_addr;
    logic [31:0] cnt_data;
    logic        cnt_clr;
    logic        dumpMem;
    logic        write_En_datachannel;
    logic [7:0]  data_datachannel;
    logic        dumpdone;

    modport master (
        output cnt_addr, cnt_clr, dumpMem, write_En_datachannel, data_datachannel,
        input  cnt_data, dumpdone
    );

    modport slave (
        input  cnt_addr, cnt_clr, dumpMem, write_En_datachannel, data_datachannel,
        output cnt_data, dumpdone
    );
endinterface

// File: rtl/hitframe_tx.sv
// Hit-counter frame transmitter: on trigger, streams NWORDS 32-bit counters MSB-first as bytes.
// Optional read-and-clear of each counter when HITFRAME_TX_CLEAR_EN is defined.
module hitframe_tx #(
    parameter int NWORDS     = 256,
    parameter int STROBE_GAP = 0
) (
    input  logic          SYSCLK,
    input  logic          reset,
    input  logic          trigger,
    output logic          busy,
    output logic          trig_dropped,
    hitframe_tx_if.master link
);
    typedef enum logic [2:0] {IDLE, REQ, FETCH, SEND, GAP, DRAIN} state_e;

    localparam logic [9:0] LAST_BYTE = 10'(4 * NWORDS - 1);
    localparam logic [7:0] LAST_WORD = 8'(NWORDS - 1);
    localparam logic [3:0] GAP_LAST  = 4'((STROBE_GAP > 0) ? STROBE_GAP - 1 : 0);

    state_e      state_q, state_d;
    logic [9:0]  bcnt_q, bcnt_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic [3:0]  gcnt_q, gcnt_d;
    logic [31:0] sreg_q, sreg_d;
    logic        done_q, done_d;
    logic        strobe, last_byte, load;

    assign strobe    = (state_q == SEND);
    assign last_byte = (bcnt_q == LAST_BYTE);
    // Next word is loaded on the strobe of byte 3; its address went out at byte 2.
    assign load      = (state_q == FETCH) | (strobe & (bcnt_q[1:0] == 2'd3) & ~last_byte);

    always_ff @(posedge SYSCLK) begin
        if (reset) begin
            state_q <= IDLE;
            bcnt_q  <= '0;
            wcnt_q  <= '0;
            gcnt_q  <= '0;
            sreg_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            wcnt_q  <= wcnt_d;
            gcnt_q  <= gcnt_d;
            sreg_q  <= sreg_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        wcnt_d  = wcnt_q;
        gcnt_d  = gcnt_q;
        sreg_d  = sreg_q;
        done_d  = done_q;
        if (state_q != IDLE && link.dumpdone) done_d = 1'b1;
        if (load) sreg_d = link.cnt_data;
        else if (strobe) sreg_d = {sreg_q[23:0], 8'h00};
        case (state_q)
            IDLE: begin
                bcnt_d = '0;
                wcnt_d = '0;
                gcnt_d = '0;
                done_d = 1'b0;
                if (trigger) state_d = REQ;
            end
            REQ:   state_d = FETCH;
            FETCH: state_d = SEND;
            SEND: begin
                bcnt_d = bcnt_q + 10'd1;
                gcnt_d = '0;
                // Advance after byte 1 so the address is stable from byte 2 onward.
                if (bcnt_q[1:0] == 2'd1 && wcnt_q != LAST_WORD) wcnt_d = wcnt_q + 8'd1;
                if (last_byte) state_d = DRAIN;
                else if (STROBE_GAP > 0) state_d = GAP;
            end
            GAP: begin
                gcnt_d = gcnt_q + 4'd1;
                if (gcnt_q == GAP_LAST) state_d = SEND;
            end
            DRAIN: begin
                if (done_q || link.dumpdone) begin
                    state_d = IDLE;
                    bcnt_d  = '0;
                    wcnt_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign link.cnt_addr             = wcnt_q;
    assign link.dumpMem              = (state_q == REQ);
    assign link.write_En_datachannel = strobe;
    assign link.data_datachannel     = strobe ? sreg_q[31:24] : 8'h00;
    assign busy                      = (state_q != IDLE);
    assign trig_dropped              = busy & trigger;

`ifdef HITFRAME_TX_CLEAR_EN
    assign link.cnt_clr = load;
`else
    assign link.cnt_clr = 1'b0;
`endif
endmodule

// File: tb/tb_hitframe_tx.sv
// Scoreboard bench for hitframe_tx: a gap-0 instance for framing/done/reset cases, a gap-3 instance for pacing.
module tb_hitframe_tx;
    typedef struct { int c; logic [7:0] v; } bexp_t;
    typedef struct { int c; int sel; logic [31:0] v; } pchk_t;

    localparam int CLR_EXP =
`ifdef HITFRAME_TX_CLEAR_EN
        256;
`else
        0;
`endif

    logic SYSCLK, reset, trig0, trig3, busy0, busy3, tdrop0, tdrop3;
    logic pat0, pat3, fin_req;
    int   cyc = 0;
    int   total = 0, bad = 0;
    int   T, TA, TB, TC, TD, TE, TG;

    bexp_t sb0[$], sb3[$];
    int    dm0[$], dm3[$], td0[$];
    pchk_t pq[$];

    hitframe_tx_if if0();
    hitframe_tx_if if3();

    hitframe_tx #(.NWORDS(256), .STROBE_GAP(0)) dut0 (
        .SYSCLK(SYSCLK), .reset(reset), .trigger(trig0),
        .busy(busy0), .trig_dropped(tdrop0), .link(if0)
    );
    hitframe_tx #(.NWORDS(256), .STROBE_GAP(3)) dut3 (
        .SYSCLK(SYSCLK), .reset(reset), .trigger(trig3),
        .busy(busy3), .trig_dropped(tdrop3), .link(if3)
    );

    initial begin
        SYSCLK = 1'b0;
        forever #5 SYSCLK = ~SYSCLK;
    end

    always @(posedge SYSCLK) cyc <= cyc + 1;

    // Pattern 1 puts distinct values in each byte lane so byte order is visible.
    function automatic logic [31:0] bank(input logic p, input logic [7:0] a);
        return p ? {a, ~a, a ^ 8'hA5, a + 8'd3} : {4{a}};
    endfunction

    function automatic logic [7:0] exp_byte(input logic p, input int n);
        logic [31:0] w;
        w = bank(p, 8'(n >> 2));
        return 8'(w >> (8 * (3 - (n % 4))));
    endfunction

    // Counter bank: one-cycle registered read.
    always @(posedge SYSCLK) begin
        if0.cnt_data <= bank(pat0, if0.cnt_addr);
        if3.cnt_data <= bank(pat3, if3.cnt_addr);
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: the only process that compares.
    int clr_exp = 0, clr_cnt = 0;
    bit fin_done = 0;
    always @(negedge SYSCLK) begin
        if (sb0.size() != 0 && sb0[0].c < cyc) begin cmp("byte0 missing (cycle)", cyc, sb0[0].c); sb0.delete(0); end
        if (if0.write_En_datachannel === 1'b1) begin
            if (sb0.size() == 0) cmp("byte0 unexpected strobe", 1, 0);
            else begin
                cmp("byte0 cycle", cyc, sb0[0].c);
                cmp("byte0 value", {24'h0, if0.data_datachannel}, {24'h0, sb0[0].v});
                sb0.delete(0);
            end
        end
        if (sb3.size() != 0 && sb3[0].c < cyc) begin cmp("byte3 missing (cycle)", cyc, sb3[0].c); sb3.delete(0); end
        if (if3.write_En_datachannel === 1'b1) begin
            if (sb3.size() == 0) cmp("byte3 unexpected strobe", 1, 0);
            else begin
                cmp("byte3 cycle", cyc, sb3[0].c);
                cmp("byte3 value", {24'h0, if3.data_datachannel}, {24'h0, sb3[0].v});
                sb3.delete(0);
            end
        end
        if (dm0.size() != 0 && dm0[0] < cyc) begin cmp("dumpMem0 missing (cycle)", cyc, dm0[0]); dm0.delete(0); end
        if (if0.dumpMem === 1'b1) begin
            clr_exp = 0;
            clr_cnt = 0;
            if (dm0.size() == 0) cmp("dumpMem0 unexpected", 1, 0);
            else begin cmp("dumpMem0 cycle", cyc, dm0[0]); dm0.delete(0); end
        end
        if (dm3.size() != 0 && dm3[0] < cyc) begin cmp("dumpMem3 missing (cycle)", cyc, dm3[0]); dm3.delete(0); end
        if (if3.dumpMem === 1'b1) begin
            if (dm3.size() == 0) cmp("dumpMem3 unexpected", 1, 0);
            else begin cmp("dumpMem3 cycle", cyc, dm3[0]); dm3.delete(0); end
        end
        if (td0.size() != 0 && td0[0] < cyc) begin cmp("trig_dropped0 missing (cycle)", cyc, td0[0]); td0.delete(0); end
        if (tdrop0 === 1'b1) begin
            if (td0.size() == 0) cmp("trig_dropped0 unexpected", 1, 0);
            else begin cmp("trig_dropped0 cycle", cyc, td0[0]); td0.delete(0); end
        end
        if (if0.cnt_clr === 1'b1) begin
            cmp("cnt_clr address", {24'h0, if0.cnt_addr}, clr_exp);
            clr_exp++;
            clr_cnt++;
        end
        while (pq.size() != 0 && pq[0].c <= cyc) begin
            case (pq[0].sel)
                0: cmp("busy0", {31'h0, busy0}, pq[0].v);
                1: cmp("strobe0", {31'h0, if0.write_En_datachannel}, pq[0].v);
                2: cmp("dumpMem0", {31'h0, if0.dumpMem}, pq[0].v);
                3: cmp("cnt_addr0", {24'h0, if0.cnt_addr}, pq[0].v);
                4: cmp("trig_dropped0", {31'h0, tdrop0}, pq[0].v);
                5: cmp("cnt_clr0", {31'h0, if0.cnt_clr}, pq[0].v);
                6: cmp("busy3", {31'h0, busy3}, pq[0].v);
                7: cmp("strobe3", {31'h0, if3.write_En_datachannel}, pq[0].v);
                default: cmp("cnt_clr pulse count", clr_cnt, pq[0].v);
            endcase
            pq.delete(0);
        end
        if (fin_req && !fin_done) begin
            fin_done = 1;
            cmp("byte0 queue drained", sb0.size(), 0);
            cmp("byte3 queue drained", sb3.size(), 0);
            cmp("dumpMem queues drained", dm0.size() + dm3.size(), 0);
            cmp("trig_dropped queue drained", td0.size(), 0);
        end
    end

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge SYSCLK);
            #1;
        end
    endtask

    task automatic chk(input int sel, input logic [31:0] v);
        pchk_t p;
        p.c = cyc; p.sel = sel; p.v = v;
        pq.push_back(p);
    endtask

    task automatic start_frame(input bit d3, input logic p, input int nb);
        int gap;
        gap = d3 ? 4 : 1;
        T = cyc;
        if (d3) begin pat3 = p; trig3 = 1'b1; dm3.push_back(T + 1); end
        else    begin pat0 = p; trig0 = 1'b1; dm0.push_back(T + 1); end
        for (int n = 0; n < nb; n++) begin
            bexp_t e;
            e.c = T + 3 + n * gap;
            e.v = exp_byte(p, n);
            if (d3) sb3.push_back(e);
            else    sb0.push_back(e);
        end
        chk(d3 ? 6 : 0, 0);
        goto(T + 1);
        trig0 = 1'b0;
        trig3 = 1'b0;
        chk(d3 ? 6 : 0, 1);
        if (!d3) chk(3, 0);
    endtask

    initial begin
        reset = 1'b1; trig0 = 1'b0; trig3 = 1'b0; pat0 = 1'b0; pat3 = 1'b0; fin_req = 1'b0;
        if0.dumpdone = 1'b0; if3.dumpdone = 1'b0;
        goto(3);
        for (int s = 0; s <= 7; s++) chk(s, 0);
        reset = 1'b0;

        // Single frame, spec pattern, late-ish dumpdone
        goto(10); start_frame(0, 1'b0, 1024); TA = T;
        goto(TA + 1027); chk(0, 1); chk(1, 0);
        goto(TA + 1030); if0.dumpdone = 1'b1;
        goto(TA + 1031); if0.dumpdone = 1'b0; chk(0, 0); chk(8, CLR_EXP);

        // Early dumpdone plus a dropped trigger mid-frame
        goto(TA + 1035); start_frame(0, 1'b1, 1024); TB = T;
        goto(TB + 500); if0.dumpdone = 1'b1;
        goto(TB + 501); if0.dumpdone = 1'b0;
        goto(TB + 600); trig0 = 1'b1; td0.push_back(TB + 600);
        goto(TB + 601); trig0 = 1'b0;
        goto(TB + 1027); chk(0, 1);
        goto(TB + 1028); chk(0, 0);

        // Late dumpdone, trigger while draining
        goto(TB + 1032); start_frame(0, 1'b1, 1024); TC = T;
        goto(TC + 1040); trig0 = 1'b1; td0.push_back(TC + 1040);
        goto(TC + 1041); trig0 = 1'b0;
        goto(TC + 1076); if0.dumpdone = 1'b1; chk(0, 1);
        goto(TC + 1077); if0.dumpdone = 1'b0; chk(0, 0);

        // Reset at strobe 300
        goto(TC + 1080); start_frame(0, 1'b0, 301); TD = T;
        goto(TD + 303); reset = 1'b1;
        goto(TD + 304); reset = 1'b0; chk(0, 0); chk(1, 0);

        // Restart from word 0 after reset
        goto(TD + 310); start_frame(0, 1'b1, 1024); TE = T;
        goto(TE + 10); if0.dumpdone = 1'b1;
        goto(TE + 11); if0.dumpdone = 1'b0;
        goto(TE + 1028); chk(0, 0);

        // Trigger together with reset: reset wins
        goto(TE + 1032); trig0 = 1'b1; reset = 1'b1;
        goto(TE + 1033); trig0 = 1'b0; reset = 1'b0; chk(0, 0); chk(2, 0);
        goto(TE + 1035); chk(0, 0);

        // Gap pacing on the STROBE_GAP=3 instance
        goto(TE + 1040); start_frame(1, 1'b1, 1024); TG = T;
        for (int c = TG + 2; c <= TG + 4095; c++) begin
            goto(c);
            chk(6, 1);
            if (c == TG + 200) if3.dumpdone = 1'b1;
            if (c == TG + 201) if3.dumpdone = 1'b0;
        end
        goto(TG + 4096); chk(6, 1); chk(7, 0);
        goto(TG + 4097); chk(6, 0);

        goto(TG + 4102);
        fin_req = 1'b1;
        repeat (3) @(negedge SYSCLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
